// File: rtl/sampdecimate_pkg.sv
// sampdecimate_pkg
//   Shared definitions for the per-channel sample rate reducer: wishbone
//   register map, MODE register encoding and the default reduction limit.
package sampdecimate_pkg;

  // Register map (wb_adr_i[1:0])
  localparam logic [1:0] REG_MODE  = 2'd0;
  localparam logic [1:0] REG_SHIFT = 2'd1;
  localparam logic [1:0] REG_DROPS = 2'd2;

  // MODE register: bit0 selects the reduction method
  localparam int MODE_AVG_BIT = 0;

  typedef enum logic {
    MODE_DECIMATE = 1'b0,
    MODE_AVERAGE  = 1'b1
  } mode_e;

  // Largest log2 reduction factor; the SHIFT field is 3 bits wide
  localparam int MAX_SHIFT_DEF = 7;
  localparam int SHIFT_W       = 3;

endpackage

// File: rtl/samppack.sv
// samppack
//   Byte-lane pack buffer. Accepts 0-2 bytes per cycle (byte_a first), fills
//   word positions 0..3 in order and reports a completed 32-bit word
//   combinationally in the cycle its fourth byte arrives. A second byte that
//   arrives with the completing byte starts the next word at position 0.
//   Ports:
//     clk, rst      clock, synchronous active-low reset
//     flush         discard buffered bytes; wins over incoming bytes
//     n_bytes       number of valid bytes this cycle (0..2)
//     byte_a/b      incoming bytes, byte_a is older
//     word          completed word (valid with word_done)
//     word_done     a word completed this cycle
//     partial_drop  flush discarded 1-3 buffered bytes this cycle
module samppack (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  n_bytes,
  input  logic [7:0]  byte_a,
  input  logic [7:0]  byte_b,
  output logic [31:0] word,
  output logic        word_done,
  output logic        partial_drop
);

  logic [1:0]  pos_p0;
  logic [23:0] buf_p0;
  logic [1:0]  pos_nxt;
  logic [23:0] buf_nxt;
  logic        done_raw;

  always_comb begin
    logic [7:0] lanes [4];
    logic [1:0] p;
    logic [7:0] bv;
    lanes[0] = buf_p0[7:0];
    lanes[1] = buf_p0[15:8];
    lanes[2] = buf_p0[23:16];
    lanes[3] = 8'd0;
    p        = pos_p0;
    bv       = 8'd0;
    word     = 32'd0;
    done_raw = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (n_bytes > k[1:0]) begin
        bv = (k == 0) ? byte_a : byte_b;
        lanes[p] = bv;
        if (p == 2'd3) begin
          done_raw = 1'b1;
          word     = {lanes[3], lanes[2], lanes[1], lanes[0]};
          lanes[0] = 8'd0;
          lanes[1] = 8'd0;
          lanes[2] = 8'd0;
          lanes[3] = 8'd0;
          p        = 2'd0;
        end else begin
          p = p + 2'd1;
        end
      end
    end
    pos_nxt = p;
    buf_nxt = {lanes[2], lanes[1], lanes[0]};
  end

  assign word_done    = done_raw & ~flush;
  assign partial_drop = flush & (pos_p0 != 2'd0);

  // ---- stage p0: buffer state ----
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      pos_p0 <= 2'd0;
      buf_p0 <= 24'd0;
    end else begin
      pos_p0 <= pos_nxt;
      buf_p0 <= buf_nxt;
    end
  end

endmodule

// File: rtl/sampdecimate.sv
// sampdecimate
//   Per-channel rate reducer between the ADC channel and the sample selector.
//   Input words carry four 8-bit samples (byte0 oldest). With SHIFT=0 words
//   pass straight through; otherwise every 2^SHIFT-th sample is kept
//   (decimate) or each 2^SHIFT group is averaged (truncating), and the
//   resulting bytes are repacked into 32-bit words.
//   Ports:
//     clk, rst            125 MHz clock, synchronous active-low reset
//     active              capture active; low discards partial state
//     in_sample/in_avail  packed input word and its valid
//     sample/sample_avail packed output word and its one-cycle strobe
//     wb_*                wishbone classic slave: MODE, SHIFT, DROPS
module sampdecimate
  import sampdecimate_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF,
  parameter int ACC_WIDTH = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic [31:0] in_sample,
  input  logic        in_avail,
  output logic [31:0] sample,
  output logic        sample_avail,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o
);

  localparam logic [7:0] MAX_SHIFT_B = 8'(MAX_SHIFT);

  function automatic logic [SHIFT_W-1:0] sat_shift(input logic [7:0] v);
    if (v > MAX_SHIFT_B) return SHIFT_W'(MAX_SHIFT);
    return v[SHIFT_W-1:0];
  endfunction

  // Group mean with truncation; the sum never exceeds 255 << sh.
  function automatic logic [7:0] avg_trunc(input logic [ACC_WIDTH-1:0] s,
                                           input logic [SHIFT_W-1:0] sh);
    return 8'(s >> sh);
  endfunction

  mode_e                mode_r;
  logic [SHIFT_W-1:0]   shift_r;
  logic [7:0]           drops_r;
  logic [6:0]           g_p0;
  logic [ACC_WIDTH-1:0] acc_p0;

  logic                 wb_req;
  logic                 wb_wr;
  logic [1:0]           reg_adr;
  logic [7:0]           rd_data;
  logic                 cfg_wr;
  logic                 flush;
  logic                 take;

  logic [6:0]           g_nxt;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [1:0]           n_emit;
  logic [7:0]           byte_a;
  logic [7:0]           byte_b;
  logic [1:0]           pack_n;
  logic [31:0]          pack_word;
  logic                 pack_done;
  logic                 pack_drop;
  logic                 unused_adr;

  assign reg_adr    = wb_adr_i[1:0];
  assign unused_adr = ^wb_adr_i[15:2];
  assign wb_req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  // Writes commit at the end of the ack cycle.
  assign wb_wr      = wb_stb_i & wb_cyc_i & wb_we_i & wb_ack_o;
  assign cfg_wr     = wb_wr & ((reg_adr == REG_MODE) | (reg_adr == REG_SHIFT));
  // A flush discards the word arriving in the same cycle.
  assign flush      = cfg_wr | ~active;
  assign take       = in_avail & ~flush;

  always_comb begin
    case (reg_adr)
      REG_MODE:  rd_data = {7'd0, mode_r};
      REG_SHIFT: rd_data = {{(8-SHIFT_W){1'b0}}, shift_r};
      REG_DROPS: rd_data = drops_r;
      default:   rd_data = 8'd0;
    endcase
  end

  // Walk the four lanes oldest-first, advancing the group counter per lane.
  always_comb begin
    logic [6:0]           mask;
    logic [6:0]           g;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;
    logic [7:0]           lane;
    logic [7:0]           emit_v;
    logic                 emit;
    mask   = ~(7'h7F << shift_r);
    g      = g_p0;
    acc    = acc_p0;
    n_emit = 2'd0;
    byte_a = 8'd0;
    byte_b = 8'd0;
    for (int i = 0; i < 4; i++) begin
      lane   = in_sample[8*i +: 8];
      emit   = 1'b0;
      emit_v = 8'd0;
      sum    = acc + ACC_WIDTH'(lane);
      if (mode_r == MODE_AVERAGE) begin
        if (g == mask) begin
          emit   = 1'b1;
          emit_v = avg_trunc(sum, shift_r);
          acc    = '0;
        end else begin
          acc = sum;
        end
      end else if (g == 7'd0) begin
        emit   = 1'b1;
        emit_v = lane;
      end
      if (emit) begin
        if (n_emit == 2'd0) begin
          byte_a = emit_v;
          n_emit = 2'd1;
        end else begin
          byte_b = emit_v;
          n_emit = 2'd2;
        end
      end
      g = (g + 7'd1) & mask;
    end
    g_nxt   = g;
    acc_nxt = acc;
  end

  // Passthrough (SHIFT=0) bypasses the packer entirely.
  assign pack_n = (take && shift_r != '0) ? n_emit : 2'd0;

  samppack u_pack (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .n_bytes      (pack_n),
    .byte_a       (byte_a),
    .byte_b       (byte_b),
    .word         (pack_word),
    .word_done    (pack_done),
    .partial_drop (pack_drop)
  );

  // ---- stage p0: group counter and accumulator ----
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      g_p0   <= 7'd0;
      acc_p0 <= '0;
    end else if (take && shift_r != '0) begin
      g_p0   <= g_nxt;
      acc_p0 <= acc_nxt;
    end
  end

  // ---- stage p1: output word and strobe ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample       <= 32'd0;
      sample_avail <= 1'b0;
    end else begin
      sample_avail <= 1'b0;
      if (take && shift_r == '0) begin
        sample       <= in_sample;
        sample_avail <= 1'b1;
      end else if (pack_done) begin
        sample       <= pack_word;
        sample_avail <= 1'b1;
      end
    end
  end

  // ---- wishbone registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'd0;
      mode_r   <= MODE_DECIMATE;
      shift_r  <= '0;
      drops_r  <= 8'd0;
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req) wb_dat_o <= rd_data;
      if (wb_wr && reg_adr == REG_MODE)  mode_r  <= mode_e'(wb_dat_i[MODE_AVG_BIT]);
      if (wb_wr && reg_adr == REG_SHIFT) shift_r <= sat_shift(wb_dat_i);
      if (wb_wr && reg_adr == REG_DROPS) drops_r <= 8'd0;
      else if (pack_drop && drops_r != 8'hFF) drops_r <= drops_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_sampdecimate.sv
// tb_sampdecimate
//   Bench for sampdecimate: directed scenarios plus randomized traffic,
//   checked every cycle against a byte-stream reference model.
module tb_sampdecimate;

  logic        clk = 1'b0;
  logic        rst;
  logic        active;
  logic [31:0] in_sample;
  logic        in_avail;
  logic [31:0] sample;
  logic        sample_avail;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  sampdecimate dut (
    .clk          (clk),
    .rst          (rst),
    .active       (active),
    .in_sample    (in_sample),
    .in_avail     (in_avail),
    .sample       (sample),
    .sample_avail (sample_avail),
    .wb_stb_i     (wb_stb_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o)
  );

  always #4 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic        act_v;
  int          m_mode, m_shift, m_drops, m_cnt, m_sum;
  logic [7:0]  m_q [$];
  logic [31:0] exp_sample;
  logic        exp_avail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] reg_model(input logic [1:0] adr);
    case (adr)
      2'd0:    return 8'(m_mode);
      2'd1:    return 8'(m_shift);
      2'd2:    return 8'(m_drops);
      default: return 8'd0;
    endcase
  endfunction

  // Model of one clock edge: the write (if any) commits, then either a
  // flush discards everything or the input word is split into samples.
  task automatic model_step(input logic act_in, input logic av, input logic [31:0] w,
                            input logic wr, input logic [1:0] adr, input logic [7:0] d);
    bit flush;
    int f;
    logic [7:0] b;
    flush = !act_in || (wr && adr <= 2'd1);
    exp_avail = 1'b0;
    if (wr) begin
      if (adr == 2'd0) m_mode = int'(d[0]);
      else if (adr == 2'd1) m_shift = (d > 8'd7) ? 7 : int'(d);
      else if (adr == 2'd2) m_drops = 0;
    end
    if (flush) begin
      if (m_q.size() > 0 && !(wr && adr == 2'd2) && m_drops < 255) m_drops++;
      m_q.delete();
      m_cnt = 0;
      m_sum = 0;
    end else if (av) begin
      if (m_shift == 0) begin
        exp_avail  = 1'b1;
        exp_sample = w;
      end else begin
        f = 1 << m_shift;
        for (int i = 0; i < 4; i++) begin
          b = w[8*i +: 8];
          if (m_mode == 0) begin
            if (m_cnt == 0) m_q.push_back(b);
          end else begin
            m_sum += int'(b);
            if (m_cnt == f - 1) begin
              m_q.push_back(8'(m_sum / f));
              m_sum = 0;
            end
          end
          m_cnt = (m_cnt + 1) % f;
        end
        if (m_q.size() >= 4) begin
          exp_sample = {m_q[3], m_q[2], m_q[1], m_q[0]};
          repeat (4) void'(m_q.pop_front());
          exp_avail = 1'b1;
        end
      end
    end
  endtask

  task automatic tick(input logic av, input logic [31:0] w,
                      input logic wr, input logic [1:0] adr, input logic [7:0] d);
    in_avail  = av;
    in_sample = w;
    active    = act_v;
    @(posedge clk);
    model_step(act_v, av, w, wr, adr, d);
    #1;
    chk("avail", 32'(sample_avail), 32'(exp_avail));
    chk("sample", sample, exp_sample);
  endtask

  task automatic feed(input logic [31:0] w);
    tick(1'b1, w, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] d,
                         input logic av2, input logic [31:0] w2, output logic [7:0] rd);
    logic [7:0] exp_rd;
    chk("ack_idle", 32'(wb_ack_o), 32'd0);
    exp_rd   = reg_model(adr);
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {14'd0, adr};
    wb_dat_i = d;
    tick(1'b0, 32'd0, 1'b0, 2'd0, 8'd0);
    chk("ack", 32'(wb_ack_o), 32'd1);
    if (!we) chk("rdata", 32'(wb_dat_o), 32'(exp_rd));
    rd = wb_dat_o;
    tick(av2, w2, we, adr, d);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    chk("ack_single", 32'(wb_ack_o), 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] adr, input logic [7:0] d);
    logic [7:0] rd;
    wb_xfer(1'b1, adr, d, 1'b0, 32'd0, rd);
  endtask

  task automatic rd_reg(input logic [1:0] adr, output logic [7:0] rd);
    wb_xfer(1'b0, adr, 8'd0, 1'b0, 32'd0, rd);
  endtask

  initial begin
    logic [7:0] rd;
    int strobes;
    rst = 1'b0; active = 1'b1; act_v = 1'b1;
    in_sample = 32'd0; in_avail = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 16'd0; wb_dat_i = 8'd0;
    m_mode = 0; m_shift = 0; m_drops = 0; m_cnt = 0; m_sum = 0;
    exp_sample = 32'd0; exp_avail = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample", sample, 32'd0);
    chk("rst_avail", 32'(sample_avail), 32'd0);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_dat", 32'(wb_dat_o), 32'd0);
    rst = 1'b1;
    rd_reg(2'd0, rd);
    rd_reg(2'd1, rd);
    rd_reg(2'd2, rd);

    // Passthrough
    feed(32'h04030201);
    chk("pass_word", sample, 32'h04030201);
    chk("pass_avail", 32'(sample_avail), 32'd1);
    tick(1'b0, 32'hDEADBEEF, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < 30; i++) tick(1'($urandom_range(0, 1)), $urandom, 1'b0, 2'd0, 8'd0);

    // Decimate by 2
    wr_reg(2'd0, 8'd0);
    wr_reg(2'd1, 8'd1);
    feed(32'h03020100);
    feed(32'h07060504);
    chk("dec_word", sample, 32'h06040200);
    chk("dec_avail", 32'(sample_avail), 32'd1);

    // Average by 4
    wr_reg(2'd0, 8'd1);
    wr_reg(2'd1, 8'd2);
    feed(32'h281E140A);
    feed(32'h04000000);
    feed(32'hFFFFFFFF);
    feed(32'h04030201);
    chk("avg4_word", sample, 32'h02FF0119);

    // Average by 128 at full scale
    wr_reg(2'd1, 8'd7);
    strobes = 0;
    for (int i = 0; i < 128; i++) begin
      feed(32'hFFFFFFFF);
      strobes += int'(sample_avail);
    end
    chk("avg128_strobes", 32'(strobes), 32'd1);
    chk("avg128_word", sample, 32'hFFFFFFFF);

    // Partial word discarded by active low
    wr_reg(2'd0, 8'd0);
    wr_reg(2'd1, 8'd1);
    feed(32'h03020100);
    act_v = 1'b0;
    tick(1'b1, 32'h11111111, 1'b0, 2'd0, 8'd0);
    chk("drop_nostrobe", 32'(sample_avail), 32'd0);
    act_v = 1'b1;
    rd_reg(2'd2, rd);
    chk("drops_one", 32'(rd), 32'd1);
    feed(32'h03020100);
    feed(32'h07060504);
    chk("after_drop_word", sample, 32'h06040200);

    // SHIFT saturation
    wr_reg(2'd1, 8'd9);
    rd_reg(2'd1, rd);
    chk("shift_sat", 32'(rd), 32'd7);

    // MODE write colliding with a completing input word
    wr_reg(2'd1, 8'd1);
    feed(32'h03020100);
    wb_xfer(1'b1, 2'd0, 8'd0, 1'b1, 32'h07060504, rd);
    chk("coll_nostrobe", 32'(sample_avail), 32'd0);
    feed(32'h03020100);
    feed(32'h07060504);
    chk("coll_restart", sample, 32'h06040200);
    rd_reg(2'd2, rd);
    chk("drops_two", 32'(rd), 32'd2);
    wr_reg(2'd2, 8'd0);
    rd_reg(2'd2, rd);
    chk("drops_clear", 32'(rd), 32'd0);

    // Randomized traffic over every mode/shift combination
    for (int md = 0; md < 2; md++) begin
      for (int sh = 0; sh < 8; sh++) begin
        wr_reg(2'd0, 8'(md));
        wr_reg(2'd1, 8'(sh));
        for (int i = 0; i < 300; i++) begin
          act_v = ($urandom_range(0, 39) != 0);
          tick(($urandom_range(0, 3) != 0), $urandom, 1'b0, 2'd0, 8'd0);
        end
        act_v = 1'b1;
        rd_reg(2'd2, rd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
